// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the mem_responder block.
package mem_responder_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT  = 8;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;
  localparam int unsigned WORD_W              = 32;
  localparam int unsigned CNT_W               = 4;  // holds wait states 0..15

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Word-addressed storage: synchronous write, registered read, no reset.
module mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write and read port share one address; callers never assert both together.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed number of wait states.
// Optional macro MEM_RESPONDER_ERR_EN flags misaligned or out-of-range addresses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEFAULT,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input logic           clock,
  input logic           reset,
  mem_responder_if.slave bus
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   write_q;
  logic [WORD_W-1:0]      wdata_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic                   accept, commit, err;
  logic                   mem_we, mem_re;
  logic [WORD_W-1:0]      mem_rdata;

`ifdef MEM_RESPONDER_ERR_EN
  logic err_q;

  // Error flag is decided from the address at accept time and held for the response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= (|bus.req_addr[1:0]) || (|(bus.req_addr >> (DEPTH_LOG2 + 2)));
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // State register and wait counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields latched on accept; ignored at all other times.
  always_ff @(posedge clock) begin
    if (accept) begin
      write_q <= bus.req_write;
      wdata_q <= bus.req_wdata;
      idx_q   <= bus.req_addr[DEPTH_LOG2+1:2];
    end
  end

  // Next-state logic: accept in idle, count down wait states, hold response until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && bus.req_ready) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_we = commit && write_q && !err;
  assign mem_re = commit && !write_q && !err;

  mem_array #(
    .ADDR_W(DEPTH_LOG2),
    .DATA_W(WORD_W)
  ) u_mem_array (
    .clock(clock),
    .we   (mem_we),
    .re   (mem_re),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  // Read data is only exposed for a successful load; reset forces idle so it drops to 0.
  assign bus.req_ready  = (state_q == StIdle) && !reset;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = (state_q == StResp && !write_q && !err) ? mem_rdata : '0;
  assign bus.resp_err   = (state_q == StResp) && err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t qm[$];
  exp_t qz[$];

  mem_responder_if bm();
  mem_responder_if bz();

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut_m (
    .clock(clk),
    .reset(rst),
    .bus  (bm)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut_z (
    .clock(clk),
    .reset(rst),
    .bus  (bz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit z, input bit v, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd);
    if (z) begin
      bz.req_valid = v; bz.req_write = wr; bz.req_addr = a; bz.req_wdata = wd;
    end else begin
      bm.req_valid = v; bm.req_write = wr; bm.req_addr = a; bm.req_wdata = wd;
    end
  endtask

  // Present one request, wait for acceptance, optionally record the expected response.
  task automatic issue(input bit z, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input bit er, input bit push);
    bit   ok = 1'b0;
    int   n = 0;
    exp_t e;
    drive(z, 1'b1, wr, a, wd);
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = z ? bz.req_ready : bm.req_ready;
      n++;
    end
    if (!ok) begin
      chk("accept_timeout", 32'(ok), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      if (push) begin
        e.rdata = rd; e.err = er; e.acc = cyc; e.lat = z ? 1 : 3;
        if (z) qz.push_back(e); else qm.push_back(e);
      end
    end
    drive(z, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_done(input bit z);
    int n = 0;
    while ((z ? qz.size() : qm.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk(z ? "z_resp_timeout" : "m_resp_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the two-wait-state instance.
  initial begin
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bm.resp_valid) begin
        if (qm.size() == 0) begin
          tests++; fails++;
          $display("FAIL m_unexpected_resp: got rdata %h with no pending request", bm.resp_rdata);
        end else begin
          e = qm[0];
          if (!seen) begin
            chk("m_latency", 32'(cyc - e.acc), 32'(e.lat));
            seen = 1'b1;
          end
          if (bm.resp_ready) begin
            chk("m_rdata", bm.resp_rdata, e.rdata);
            chk("m_err", 32'(bm.resp_err), 32'(e.err));
            void'(qm.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Monitor for the zero-wait-state instance.
  initial begin
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bz.resp_valid) begin
        if (qz.size() == 0) begin
          tests++; fails++;
          $display("FAIL z_unexpected_resp: got rdata %h with no pending request", bz.resp_rdata);
        end else begin
          e = qz[0];
          if (!seen) begin
            chk("z_latency", 32'(cyc - e.acc), 32'(e.lat));
            seen = 1'b1;
          end
          if (bz.resp_ready) begin
            chk("z_rdata", bz.resp_rdata, e.rdata);
            chk("z_err", 32'(bz.resp_err), 32'(e.err));
            void'(qz.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bm.resp_ready = 1'b1;
    bz.resp_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bm.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bm.resp_valid), 32'd0);
    chk("rst_resp_rdata", bm.resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(bm.resp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(bm.req_ready), 32'd1);
    @(posedge clk); #1;

    // Store then load at 0x10
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_done(1'b0);

    // Response stall with a competing request held on the bus
    bm.resp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bm.resp_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      chk("stall_resp_valid", 32'(bm.resp_valid), 32'd1);
      chk("stall_resp_rdata", bm.resp_rdata, 32'hDEADBEEF);
      chk("stall_req_ready", 32'(bm.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bm.resp_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done(1'b0);
    chk("stall_after_valid", 32'(bm.resp_valid), 32'd0);
    chk("stall_after_ready", 32'(bm.req_ready), 32'd1);

    // Out-of-range store: aliases to word 0, or is rejected with the error build
    issue(1'b0, 1'b1, 32'h0, 32'h77, 32'h0, 1'b0, 1'b1);
    wait_done(1'b0);
`ifdef MEM_RESPONDER_ERR_EN
    issue(1'b0, 1'b1, 32'h400, 32'h1, 32'h0, 1'b1, 1'b1);
    wait_done(1'b0);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h77, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_done(1'b0);
`else
    issue(1'b0, 1'b1, 32'h400, 32'h1, 32'h0, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(1'b0, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_done(1'b0);
`endif

    // Reset during WAIT must abort an uncommitted store
    issue(1'b0, 1'b1, 32'h20, 32'h55, 32'h0, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(1'b0, 1'b1, 32'h20, 32'hAA, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_req_ready", 32'(bm.req_ready), 32'd0);
    chk("abort_resp_valid", 32'(bm.resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_post_ready", 32'(bm.req_ready), 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'h20, 32'h0, 32'h55, 1'b0, 1'b1);
    wait_done(1'b0);

    // Zero wait states: one-edge latency
    issue(1'b1, 1'b1, 32'h8, 32'h12345678, 32'h0, 1'b0, 1'b1);
    wait_done(1'b1);
    issue(1'b1, 1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0, 1'b1);
    wait_done(1'b1);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of word count (256 x 32-bit words, 1 KB).
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait states per access (legal range 0..15).
REQ-003 Port clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  initiator presents a request.
REQ-006 Port req_ready  output  1  responder can accept a request.
REQ-007 Port req_write  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data.
REQ-010 Port resp_valid  output  1  response available.
REQ-011 Port resp_ready  input  1  initiator takes the response.
REQ-012 Port resp_rdata  output  32  load data; 0 for store responses.
REQ-013 Port resp_err  output  1  error flag (see Configuration).

Function
REQ-014 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE and reset-deasserted.
REQ-015 Accept on an edge with req_valid && req_ready: latch write, addr, wdata; load counter = WAIT_CYCLES; go WAIT.
REQ-016 In WAIT: counter != 0 -> decrement; counter == 0 -> commit access, go RESP.
REQ-017 resp_valid SHALL rise exactly WAIT_CYCLES+1 edges after the accepting edge.
REQ-018 Word index = addr[DEPTH_LOG2+1:2]; store writes mem[index] at the commit edge; load captures mem[index] into resp_rdata at the same edge.
REQ-019 In RESP, resp_valid, resp_rdata, resp_err SHALL hold stable until an edge with resp_ready = 1, then go IDLE.
REQ-020 No new request is accepted in the cycle a response completes; minimum period = WAIT_CYCLES+3 cycles per transaction.
REQ-021 req_* inputs SHALL be ignored outside IDLE; they are not sampled after acceptance.
REQ-022 Store followed by load of the same index returns the stored value (no stale read).

Reset
REQ-023 Asserting reset SHALL immediately force IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 0 (1 from the first cycle after deassertion).
REQ-024 Reset during WAIT aborts the transaction; a store not yet committed SHALL NOT modify memory.
REQ-025 Memory contents are not reset.

Configuration
REQ-026 Macro MEM_RESPONDER_ERR_EN defined: addr[1:0] != 0 or any addr bit above DEPTH_LOG2+1 set -> no memory access, resp_err = 1, resp_rdata = 0, identical latency.
REQ-027 Macro undefined: resp_err constant 0; addr[1:0] and upper bits ignored (aliasing by wrap-around).

Structure
REQ-028 Shared package mem_responder_pkg holds state enum, default DEPTH_LOG2/WAIT_CYCLES constants, word width 32.
REQ-029 One sub-module mem_array: synchronous write, registered read, DEPTH_LOG2 address bits, no reset.

Verification
REQ-030 Reset, store 0xDEADBEEF @0x10, load @0x10 -> resp_rdata 0xDEADBEEF, resp_valid 3 edges after accept (WAIT_CYCLES=2).
REQ-031 resp_ready held 0 for 5 cycles with req_valid = 1 -> resp_valid/resp_rdata stable, req_ready 0, no second accept.
REQ-032 Macro off: store 0x1 @0x400, load @0x000 -> 0x1; macro on: store @0x400 -> resp_err 1, load @0x000 unchanged.
REQ-033 Macro on: load @0x13 -> resp_err 1, resp_rdata 0, latency 3.
REQ-034 Store 0x55 @0x20, then store 0xAA @0x20 with reset pulsed during WAIT -> after reset, load @0x20 returns 0x55, req_ready 1.
REQ-035 WAIT_CYCLES=0: load -> resp_valid 1 edge after accept.
